// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with a clock-enable prescaler,
// synchronous clear/load, wrap or saturate at the range ends, and a hex
// 7-segment decode of the low nibble of the binary count.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   en_i        count enable (gates prescaler and stepping)
//   up_i        direction, 1 = increment, 0 = decrement
//   clr_i       synchronous clear (highest priority)
//   load_i      synchronous load of load_val_i
//   load_val_i  binary load value
//   gray_o      registered Gray-coded count
//   bin_o       registered binary count
//   tick_o      one-cycle pulse in the cycle the count stepped
//   wrap_o      one-cycle pulse on a wrap or saturation event
//   seg_o       {a,b,c,d,e,f,g}, active-low hex digit of bin_o[3:0]
module gray_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             tick_o,
  output logic             wrap_o,
  output logic [6:0]       seg_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] B_MAX  = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [3:0]       nib;

  always_comb begin
    bin_d  = bin_q;
    pre_d  = pre_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (clr_i) begin
      bin_d = '0;
      pre_d = '0;
    end else if (load_i) begin
      bin_d = load_val_i;
      pre_d = '0;
    end else if (en_i) begin
      if (pre_q == P_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (up_i) begin
          if (bin_q == B_MAX) begin
            wrap_d = 1'b1;
            bin_d  = (SATURATE != 0) ? bin_q : '0;
          end else begin
            bin_d = bin_q + 1'b1;
          end
        end else begin
          if (bin_q == '0) begin
            wrap_d = 1'b1;
            bin_d  = (SATURATE != 0) ? bin_q : B_MAX;
          end else begin
            bin_d = bin_q - 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    // Gray is derived from the next binary value so both registers
    // update on the same edge and never disagree.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      gray_q <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      pre_q  <= pre_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  // Cast zero-extends narrow counters and truncates wide ones to the nibble.
  assign nib = 4'(bin_q);

  always_comb begin
    seg_o = 7'b1111111;
    case (nib)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = 7'b1111111;
    endcase
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign tick_o = tick_q;
  assign wrap_o = wrap_q;

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
Parametrised up/down Gray-code counter with an integrated clock-enable prescaler, synchronous load/clear, wrap or saturate mode, and a hex 7-segment decode of the count's low nibble. It replaces the fixed-width up-only Gray counter in display/demo designs. It runs entirely in the system clock domain: the prescaler produces a count-enable tick, not a derived clock. It drives board LEDs (gray_o/bin_o) and one 7-segment digit.

Parameters:
WIDTH, 8, counter width in bits; legal range 2..32.
CLK_DIV, 4, system clocks per count step; legal range 1..2^24; 1 = step every enabled cycle.
SATURATE, 0, 0 = wrap at the ends of the range, 1 = hold at the ends of the range.

Ports:
clk_i  in  1  system clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
en_i  in  1  count enable; gates both the prescaler and stepping.
up_i  in  1  direction: 1 = increment, 0 = decrement (sampled on the tick cycle).
clr_i  in  1  synchronous clear to 0.
load_i  in  1  synchronous load of load_val_i.
load_val_i  in  WIDTH  binary value to load.
gray_o  out  WIDTH  registered Gray-coded count.
bin_o  out  WIDTH  registered binary count.
tick_o  out  1  registered; pulses 1 cycle in the cycle the count steps.
wrap_o  out  1  registered; pulses 1 cycle on a wrap or saturation event.
seg_o  out  7  {a,b,c,d,e,f,g}, active-low, hex digit of bin_o[3:0].

Behaviour:
- Reset (rst_ni=0, asynchronous): bin_o=0, gray_o=0, prescaler=0, tick_o=0, wrap_o=0. seg_o decodes 0 (7'b0000001). Deassertion takes effect on the next clk_i edge.
- Internal state: binary counter B (WIDTH bits) and prescaler P (0..CLK_DIV-1). gray_o is registered as next_B ^ (next_B>>1), in the same cycle as bin_o; the two are never skewed.
- Priority, per clock edge: clr_i > load_i > count.
  - clr_i=1: B=0, P=0; tick_o=0, wrap_o=0.
  - else load_i=1: B=load_val_i, P=0; tick_o=0, wrap_o=0.
  - Both clr and load act regardless of en_i.
- Count path, when en_i=1 and no clr/load:
  - If P==CLK_DIV-1: P=0, a step occurs, tick_o=1 next cycle. Otherwise P=P+1.
  - en_i=0 freezes P and B; tick_o and wrap_o go 0.
- Step rules:
  - up at B=2^WIDTH-1: SATURATE=0 -> B=0; SATURATE=1 -> B holds. wrap_o=1 in both cases.
  - down at B=0: SATURATE=0 -> B=2^WIDTH-1; SATURATE=1 -> B holds. wrap_o=1 in both cases.
  - Otherwise B=B±1 and wrap_o=0.
- Latency: with CLK_DIV=N and en_i held high from P=0, the first step is visible on bin_o/gray_o after N rising edges. tick_o asserts in the same cycle as the new value.
- Gray property: each non-saturated step changes exactly one bit of gray_o, including across the wrap.
- Direction changes take effect at the next tick. Changing up_i mid-prescale does not reset P.
- seg_o is combinational from registered bin_o[3:0], hex 0..F:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - For WIDTH<4, bin_o is zero-extended before decode.
- Reset mid-operation: all state returns to the reset values immediately, independent of clk_i.

Test Plan:
1. WIDTH=4, CLK_DIV=1, en_i=1, up_i=1 from reset -> gray_o steps 0000,0001,0011,0010,0110,0111,0101,0100,1100,... on consecutive cycles. After 15 steps, bin_o=15, gray_o=1000, seg_o=0111000. The 16th step gives bin_o=0, wrap_o=1 for 1 cycle, and gray_o changes by a single bit.
2. WIDTH=4, CLK_DIV=1, up_i=0 from reset -> bin_o=15, gray_o=1000, wrap_o=1. The next step gives bin_o=14, gray_o=1001.
3. CLK_DIV=3, en_i=1 -> bin_o increments on edges 3,6,9, with tick_o=1 only in those cycles. Dropping en_i for 5 cycles at P=1 -> the next step arrives 2 enabled cycles after en_i returns.
4. Load/clear, CLK_DIV=1: load_i=1, load_val_i=0xA5 -> bin_o=0xA5, gray_o=0xF7, seg_o=0100100. Asserting clr_i and load_i together -> bin_o=0.
5. SATURATE=1, WIDTH=4: load 14, count up 3 steps -> bin_o=15,15,15, with wrap_o=1 on the 2nd and 3rd steps. Count down from a load of 0 -> bin_o stays 0 and wrap_o pulses.
6. Drive rst_ni low between clock edges mid-count (bin_o=7) -> bin_o=0, gray_o=0, seg_o=0000001 without a clock edge. Counting resumes from 0 after release.
